// File: rtl/mcu_pkg.sv
// Shared types and constants for the multi-cycle RV32I-subset controller.
// States, opcodes, ALU operations, immediate formats and mux selects.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_LUI,
        S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_t;

    localparam logic [1:0] SRCA_PC    = 2'd0;
    localparam logic [1:0] SRCA_OLDPC = 2'd1;
    localparam logic [1:0] SRCA_RS1   = 2'd2;
    localparam logic [1:0] SRCA_ZERO  = 2'd3;

    localparam logic [1:0] SRCB_RS2   = 2'd0;
    localparam logic [1:0] SRCB_IMM   = 2'd1;
    localparam logic [1:0] SRCB_FOUR  = 2'd2;

    localparam logic [1:0] RES_ALUOUT = 2'd0;
    localparam logic [1:0] RES_MEM    = 2'd1;
    localparam logic [1:0] RES_ALU    = 2'd2;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// ALU operation decoder for register and immediate arithmetic.
// Unsupported funct3 values are reported through legal=0.
module alu_decoder
    import mcu_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       is_rtype,
    output logic [2:0] alu_ctrl,
    output logic       legal
);

    // funct3 selects the operation; funct7[5] only means sub for R-type
    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b1;
        case (funct3)
            3'b000:  alu_ctrl = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
            3'b010:  alu_ctrl = ALU_SLT;
            3'b110:  alu_ctrl = ALU_OR;
            3'b111:  alu_ctrl = ALU_AND;
            default: legal    = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I-subset controller driving a shared ALU and unified memory port.
// Adds a memory wait handshake, a sticky illegal-opcode trap and an instret counter.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ALU_CTRL_WIDTH = 3,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     instr,
    input  logic                      EQ,
    input  logic                      mem_ready,
    output logic                      PCWrite,
    output logic                      IRWrite,
    output logic                      RegWrite,
    output logic                      MemWrite,
    output logic                      AdrSrc,
    output logic [1:0]                ALUSrcA,
    output logic [1:0]                ALUSrcB,
    output logic [1:0]                ResultSrc,
    output logic [2:0]                ImmSrc,
    output logic [ALU_CTRL_WIDTH-1:0] ALUctrl,
    output logic                      illegal,
    output logic [CNT_WIDTH-1:0]      instret
);

    state_t     state;
    state_t     next_state;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [2:0] dec_ctrl;
    logic       dec_legal;
    logic [2:0] alu_op;
    logic       retire;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign funct3      = instr[14:12];
    assign unused_bits = ^{instr[DATA_WIDTH-1:31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .funct3   (funct3),
        .funct7_5 (instr[30]),
        .is_rtype (state == S_EXEC_R),
        .alu_ctrl (dec_ctrl),
        .legal    (dec_legal)
    );

    // State, sticky trap flag and retired-instruction counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            illegal <= 1'b0;
            instret <= '0;
        end else begin
            state <= next_state;
            if (next_state == S_TRAP) begin
                illegal <= 1'b1;
            end
            if (retire) begin
                instret <= instret + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state logic and Moore/handshake-gated control outputs
    always_comb begin
        next_state = state;
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        RegWrite   = 1'b0;
        MemWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RS2;
        ResultSrc  = RES_ALUOUT;
        ImmSrc     = IMM_I;
        alu_op     = ALU_ADD;
        retire     = 1'b0;

        unique case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALU;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculative branch/jump target lands in ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                ImmSrc  = (opcode == OP_JAL) ? IMM_J : IMM_B;
                case (opcode)
                    OP_LOAD,
                    OP_STORE:  next_state = S_MEMADR;
                    OP_RTYPE:  next_state = S_EXEC_R;
                    OP_ITYPE:  next_state = S_EXEC_I;
                    OP_BRANCH: next_state = S_BRANCH;
                    OP_JAL:    next_state = S_JAL;
                    OP_LUI:    next_state = S_LUI;
                    default:   next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                if (opcode == OP_STORE) begin
                    ImmSrc     = IMM_S;
                    next_state = S_MEMWRITE;
                end else begin
                    next_state = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ResultSrc  = RES_MEM;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    retire     = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXEC_R,
            S_EXEC_I: begin
                ALUSrcA    = SRCA_RS1;
                ALUSrcB    = (state == S_EXEC_R) ? SRCB_RS2 : SRCB_IMM;
                alu_op     = dec_ctrl;
                next_state = dec_legal ? S_ALUWB : S_TRAP;
            end
            S_ALUWB: begin
                ResultSrc  = RES_ALUOUT;
                RegWrite   = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ResultSrc = RES_ALUOUT;
                alu_op    = ALU_SUB;
                case (funct3)
                    3'b000: begin
                        PCWrite    = EQ;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    3'b001: begin
                        PCWrite    = !EQ;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_TRAP;
                endcase
            end
            S_JAL: begin
                // PC takes the jump target from ALUOut; ALU forms OldPC+4 for rd
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                ImmSrc     = IMM_J;
                ResultSrc  = RES_ALUOUT;
                PCWrite    = 1'b1;
                next_state = S_ALUWB;
            end
            S_LUI: begin
                ALUSrcA    = SRCA_ZERO;
                ALUSrcB    = SRCB_IMM;
                ImmSrc     = IMM_U;
                next_state = S_ALUWB;
            end
            S_TRAP: begin
                next_state = S_TRAP;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        // Reset forces every control output low, even mid-instruction
        if (rst) begin
            PCWrite   = 1'b0;
            IRWrite   = 1'b0;
            RegWrite  = 1'b0;
            MemWrite  = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = '0;
            ALUSrcB   = '0;
            ResultSrc = '0;
            ImmSrc    = '0;
            alu_op    = '0;
            retire    = 1'b0;
        end

        ALUctrl = ALU_CTRL_WIDTH'(alu_op);
    end

endmodule
